load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - CPU-side initiator for data_memory. Takes one load/store request at a time from the core.
// - Drives the memory port: address, write_data, write_enable, dm_ctrl. Returns the load result.
// - Splits naturally-misaligned accesses: loads become 2 word reads; stores become byte stores.
// - Range-checks every access and counts split accesses for the VGA debug view.
// PARAMETERS
// - MEM_BYTES  256  data memory size in bytes; an access whose last byte >= MEM_BYTES faults
// - CNT_W      16   width of split_count
// PORTS
// - clk            in   1      system clock
// - rst_n          in   1      synchronous, active-low reset
// - req_valid      in   1      core request valid
// - req_ready      out  1      unit idle, request accepted when req_valid & req_ready
// - req_write      in   1      1 = store, 0 = load
// - req_funct3     in   3      RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
// - req_addr       in   32     byte address
// - req_wdata      in   32     store data (LSBs used for SB/SH)
// - resp_valid     out  1      response valid, held until resp_ready
// - resp_ready     in   1      core accepts response
// - resp_rdata     out  32     extended load data; 0 for stores and faults
// - resp_fault     out  1      bad address range or illegal funct3; qualified by resp_valid
// - mem_address    out  32     to data_memory address
// - mem_write_data out  32     to data_memory write_data
// - mem_write_enable out 1     to data_memory write_enable
// - mem_dm_ctrl    out  3      to data_memory dm_ctrl
// - mem_read_data  in   32     from data_memory read_data (combinational read)
// - split_count    out  CNT_W  number of split (misaligned) accesses; saturates at all-ones
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, split_count=0.
// - Reset: mem_write_enable=0 and combinationally gated by rst_n, so no write occurs in a reset cycle, even mid-store.
// - FSM states: IDLE, LD_LO, LD_HI, ST_ONE, ST_BYTE, RESP.
// - Outside LD_*/ST_*: mem_write_enable=0, mem_address=0, mem_dm_ctrl=3'b010.
// - IDLE: req_ready=1. On req_valid, capture addr, wdata, funct3, write, then decode:
//   - Illegal funct3 (load 011/110/111; store anything but 000/001/010) -> RESP with fault.
//   - Range fault (addr+size-1 >= MEM_BYTES; compute in 33 bits so no wrap) -> RESP with fault. No memory cycle.
//   - Load -> LD_LO.
//   - Aligned store (half addr[0]=0, word addr[1:0]=0) -> ST_ONE.
//   - Misaligned store -> ST_BYTE with byte index i=0, count N=size.
// - LD_LO: address={addr[31:2],2'b00}, dm_ctrl=010. Register mem_read_data into lo.
//   - Next is LD_HI if offset+size>4, else RESP.
// - LD_HI: address=aligned+4, dm_ctrl=010, register into hi. Next RESP.
// - Load data: byte-shift {hi,lo} right by 8*addr[1:0], take size bytes, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
// - ST_ONE: address=addr, dm_ctrl=funct3, write_data=wdata, we=1 for one cycle. Next RESP.
// - ST_BYTE: address=addr+i, dm_ctrl=000, write_data={24'b0, wdata[8i+7:8i]}, we=1. i increments each cycle.
//   - After byte N-1 -> RESP.
// - RESP: resp_valid=1, outputs stable. On resp_ready, go to IDLE (req_ready=1 the next cycle).
// - Latency (accept edge = cycle 0, zero-wait resp_ready), resp_valid first high in:
//   - fault: cycle 1
//   - aligned or in-word load: cycle 2
//   - spanning load: cycle 3
//   - aligned store: cycle 2
//   - misaligned store: cycle N+1
// - split_count increments once per accepted request that is a spanning load or a misaligned store, at decode.
//   - Faulted requests never count. Counter saturates, no wrap.
// - Back-to-back requests: no request is accepted while not IDLE. req_ready=0 from the accept edge until return to IDLE.
// TESTING (memory preloaded: word0=0x12345678, word1=0xABCDEF00, word4=0x000000FF, word5=0x80000000)
// - LW 0x00 -> resp_rdata=0x12345678, resp_fault=0, resp_valid at cycle 2, split_count=0.
// - LW 0x02 -> 2 reads (0x00, 0x04), resp_rdata=0xEF001234 at cycle 3, split_count=1.
// - LH 0x05 -> single read, 0xFFFFCDEF. LHU 0x05 -> 0x0000CDEF. LB 0x07 -> 0xFFFFFFAB.
// - SW 0x11 wdata 0xAABBCCDD -> 4 SB cycles at 0x11..0x14 (DD,CC,BB,AA).
//   - Then LW 0x10=0xBBCCDDFF and LW 0x14=0x800000AA.
// - LW 0xFE -> resp_fault=1, resp_rdata=0, no memory cycle.
//   - Funct3 011 load -> fault. resp_ready held 0 for 5 cycles -> resp_valid and outputs stay stable.
// - SW 0x21 with rst_n=0 during 2nd byte cycle -> only byte 0x21 written. Next cycle req_ready=1, split_count=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// CPU-side initiator for data_memory. Accepts one load/store at a time from the
// core, drives the memory port, and returns extended load data.
// Naturally-misaligned loads become two word reads (low word then high word).
// Misaligned stores become a run of byte stores. Every access is range-checked
// against MEM_BYTES. Split accesses are counted for the debug view.
//
// Handshakes: a request transfers on a clock edge where req_valid & req_ready
// are both high. A response transfers on an edge where resp_valid & resp_ready
// are both high. resp_valid, resp_rdata and resp_fault stay constant until that
// edge. req_ready is high only in IDLE.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write, req_funct3      store flag and RISC-V funct3
//   req_addr, req_wdata        byte address and store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_fault     load result (0 for stores and faults) and fault flag
//   mem_address, mem_write_data, mem_write_enable, mem_dm_ctrl  to data_memory
//   mem_read_data              from data_memory (combinational read)
//   split_count                saturating count of split accesses
module load_store_unit #(
  parameter int MEM_BYTES = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_fault,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic             mem_write_enable,
  output logic [2:0]       mem_dm_ctrl,
  input  logic [31:0]      mem_read_data,
  output logic [CNT_W-1:0] split_count
);

  typedef enum logic [2:0] {IDLE, LD_LO, LD_HI, ST_ONE, ST_BYTE, RESP} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, lo_q;
  logic [2:0]  f3_q;
  logic        write_q;
  logic [1:0]  idx_q;
  logic        we_c;

  // Request decode. It is only acted on in IDLE.
  logic [2:0]  req_size;
  logic [32:0] req_last;
  logic        req_illegal, req_range_bad, req_fault, req_aligned, req_spans, req_split;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
  end

  // The last byte is computed in 33 bits so that addresses near 2^32 cannot wrap into range.
  assign req_last      = {1'b0, req_addr} + 33'(req_size) - 33'd1;
  assign req_range_bad = req_last >= 33'(MEM_BYTES);
  assign req_illegal   = req_write ? (req_funct3 > 3'b010)
                                   : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign req_fault     = req_illegal | req_range_bad;
  assign req_aligned   = (req_funct3[1:0] == 2'b00) ||
                         ((req_funct3[1:0] == 2'b01) && !req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00));
  assign req_spans     = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
  assign req_split     = !req_fault && (req_write ? !req_aligned : req_spans);

  // Values derived from the captured request
  logic [2:0]  q_size;
  logic        q_spans;
  logic [31:0] lo_src, hi_src, shifted, load_data;
  logic [7:0]  store_byte;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   q_size = 3'd1;
      2'b01:   q_size = 3'd2;
      default: q_size = 3'd4;
    endcase
  end

  assign q_spans = ({1'b0, addr_q[1:0]} + q_size) > 3'd4;

  // In LD_LO the low word arrives straight from memory and the high word is unused.
  // In LD_HI the low word comes from lo_q and the high word from memory.
  assign lo_src  = (state == LD_HI) ? lo_q : mem_read_data;
  assign hi_src  = (state == LD_HI) ? mem_read_data : 32'd0;
  assign shifted = 32'({hi_src, lo_src} >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign store_byte = 8'(wdata_q >> {idx_q, 3'b000});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and memory-port outputs
  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    mem_dm_ctrl    = 3'b010;
    we_c           = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault)        state_next = RESP;
          else if (!req_write)  state_next = LD_LO;
          else if (req_aligned) state_next = ST_ONE;
          else                  state_next = ST_BYTE;
        end
      end
      LD_LO: begin
        mem_address = {addr_q[31:2], 2'b00};
        state_next  = q_spans ? LD_HI : RESP;
      end
      LD_HI: begin
        mem_address = {addr_q[31:2], 2'b00} + 32'd4;
        state_next  = RESP;
      end
      ST_ONE: begin
        mem_address    = addr_q;
        mem_dm_ctrl    = f3_q;
        mem_write_data = wdata_q;
        we_c           = 1'b1;
        state_next     = RESP;
      end
      ST_BYTE: begin
        mem_address    = addr_q + {30'd0, idx_q};
        mem_dm_ctrl    = 3'b000;
        mem_write_data = {24'd0, store_byte};
        we_c           = 1'b1;
        if ({1'b0, idx_q} == (q_size - 3'd1)) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst_n blocks writes in any reset cycle, including one in the middle of a store.
  assign mem_write_enable = we_c & rst_n;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      f3_q        <= 3'd0;
      write_q     <= 1'b0;
      lo_q        <= 32'd0;
      idx_q       <= 2'd0;
      resp_rdata  <= 32'd0;
      resp_fault  <= 1'b0;
      split_count <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          f3_q       <= req_funct3;
          write_q    <= req_write;
          idx_q      <= 2'd0;
          resp_rdata <= 32'd0;
          resp_fault <= req_fault;
          if (req_split && (split_count != '1)) split_count <= split_count + 1'b1;
        end
        LD_LO: begin
          lo_q <= mem_read_data;
          if (!q_spans) resp_rdata <= load_data;
        end
        LD_HI:   resp_rdata <= load_data;
        ST_BYTE: idx_q <= idx_q + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. It uses a small byte-array data memory
// with a combinational word read and byte/half/word writes selected by dm_ctrl.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic [2:0]  mem_dm_ctrl;
  logic [15:0] split_count;

  load_store_unit #(.MEM_BYTES(256), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_dm_ctrl(mem_dm_ctrl),
    .mem_read_data(mem_read_data), .split_count(split_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model
  logic [7:0] mem [256];
  logic       preload;
  int         wr_cnt;
  logic [7:0] ra, wa;

  always_comb begin
    ra = {mem_address[7:2], 2'b00};
    mem_read_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      {mem[3], mem[2], mem[1], mem[0]}         <= 32'h12345678;
      {mem[7], mem[6], mem[5], mem[4]}         <= 32'hABCDEF00;
      {mem[19], mem[18], mem[17], mem[16]}     <= 32'h000000FF;
      {mem[23], mem[22], mem[21], mem[20]}     <= 32'h80000000;
      wr_cnt <= 0;
    end else if (mem_write_enable) begin
      wa = mem_address[7:0];
      wr_cnt <= wr_cnt + 1;
      mem[wa] <= mem_write_data[7:0];
      if (mem_dm_ctrl[1:0] != 2'b00) mem[wa + 8'd1] <= mem_write_data[15:8];
      if (mem_dm_ctrl[1:0] == 2'b10) begin
        mem[wa + 8'd2] <= mem_write_data[23:16];
        mem[wa + 8'd3] <= mem_write_data[31:24];
      end
    end
  end

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  int          lat;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_addrs(input string tag);
    check({tag, " n"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, " addr"}, obs_q[i], exp_q[i]);
  endtask

  // driver: issue one request and wait for resp_valid (bounded), logging the memory address of each busy cycle
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    obs_q.delete();
    @(negedge clk);
    check("req_ready idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      obs_q.push_back(mem_address);
    end
    if (!resp_valid) begin
      total++; bad++;
      $error("FAIL resp timeout observed=%0d expected=<20", lat);
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp_data, input int exp_lat);
    do_req(1'b0, f3, a, 32'd0);
    check({tag, " data"}, resp_rdata, exp_data);
    check({tag, " fault"}, 32'(resp_fault), 32'd0);
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    ack();
  endtask

  int wr_before;

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_fault", 32'(resp_fault), 32'd0);
    check("rst split", 32'(split_count), 32'd0);
    check("rst we", 32'(mem_write_enable), 32'd0);
    check("rst addr", mem_address, 32'd0);
    check("rst dm_ctrl", 32'(mem_dm_ctrl), 32'd2);
    preload = 1'b0; rst_n = 1'b1;

    // LW 0x00: aligned
    do_req(1'b0, 3'b010, 32'h00, 32'd0);
    check("lw00 data", resp_rdata, 32'h12345678);
    check("lw00 fault", 32'(resp_fault), 32'd0);
    check("lw00 lat", 32'(lat), 32'd2);
    check("lw00 split", 32'(split_count), 32'd0);
    exp_q = '{32'h00}; check_addrs("lw00");
    ack();

    // LW 0x02: spans two words
    do_req(1'b0, 3'b010, 32'h02, 32'd0);
    check("lw02 data", resp_rdata, 32'hEF001234);
    check("lw02 lat", 32'(lat), 32'd3);
    check("lw02 split", 32'(split_count), 32'd1);
    check("lw02 req_ready busy", 32'(req_ready), 32'd0);
    exp_q = '{32'h00, 32'h04}; check_addrs("lw02");
    ack();

    load_chk("lh05", 3'b001, 32'h05, 32'hFFFFCDEF, 2);
    exp_q = '{32'h04}; check_addrs("lh05");
    load_chk("lhu05", 3'b101, 32'h05, 32'h0000CDEF, 2);
    load_chk("lb07", 3'b000, 32'h07, 32'hFFFFFFAB, 2);
    load_chk("lbu07", 3'b100, 32'h07, 32'h000000AB, 2);
    check("split after in-word", 32'(split_count), 32'd1);

    // SW 0x11: misaligned word store -> 4 byte stores
    wr_before = wr_cnt;
    do_req(1'b1, 3'b010, 32'h11, 32'hAABBCCDD);
    check("sw11 lat", 32'(lat), 32'd5);
    check("sw11 data", resp_rdata, 32'd0);
    check("sw11 fault", 32'(resp_fault), 32'd0);
    check("sw11 split", 32'(split_count), 32'd2);
    exp_q = '{32'h11, 32'h12, 32'h13, 32'h14}; check_addrs("sw11");
    ack();
    check("sw11 writes", 32'(wr_cnt - wr_before), 32'd4);
    load_chk("lw10", 3'b010, 32'h10, 32'hBBCCDDFF, 2);
    load_chk("lw14", 3'b010, 32'h14, 32'h800000AA, 2);

    // SH 0x18: aligned half store
    do_req(1'b1, 3'b001, 32'h18, 32'h1234BEEF);
    check("sh18 lat", 32'(lat), 32'd2);
    ack();
    load_chk("lw18", 3'b010, 32'h18, 32'h0000BEEF, 2);
    check("split after sh", 32'(split_count), 32'd2);

    // Range boundary: last byte 0xFF is fine, one past is a fault
    load_chk("lbff", 3'b000, 32'hFF, 32'h00000000, 2);
    wr_before = wr_cnt;
    do_req(1'b0, 3'b010, 32'hFE, 32'd0);
    check("lwfe fault", 32'(resp_fault), 32'd1);
    check("lwfe data", resp_rdata, 32'd0);
    check("lwfe lat", 32'(lat), 32'd1);
    check("lwfe split", 32'(split_count), 32'd2);
    ack();
    do_req(1'b1, 3'b001, 32'hFF, 32'h1111);
    check("shff fault", 32'(resp_fault), 32'd1);
    check("shff writes", 32'(wr_cnt - wr_before), 32'd0);
    check("shff split", 32'(split_count), 32'd2);
    ack();

    // Illegal load funct3, with the response held for 5 cycles
    do_req(1'b0, 3'b011, 32'h00, 32'd0);
    check("ld011 lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold valid", 32'(resp_valid), 32'd1);
      check("hold fault", 32'(resp_fault), 32'd1);
      check("hold data", resp_rdata, 32'd0);
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    ack();

    // Illegal store funct3
    do_req(1'b1, 3'b100, 32'h00, 32'd0);
    check("st100 fault", 32'(resp_fault), 32'd1);
    ack();

    // SW 0x21 with reset asserted during the second byte cycle
    wr_before = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h21; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("sw21 split", 32'(split_count), 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("sw21 we gated", 32'(mem_write_enable), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("sw21 req_ready", 32'(req_ready), 32'd1);
    check("sw21 split rst", 32'(split_count), 32'd0);
    check("sw21 resp_valid", 32'(resp_valid), 32'd0);
    check("sw21 writes", 32'(wr_cnt - wr_before), 32'd1);
    check("sw21 b21", 32'(mem[8'h21]), 32'h44);
    check("sw21 b22", 32'(mem[8'h22]), 32'h00);
    check("sw21 b23", 32'(mem[8'h23]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
